// File: rtl/vend_pkg.sv
// Shared types for the vending change sequencer: coin encoding, coin values
// and controller states.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_N = 2'b00,
    COIN_D = 2'b01,
    COIN_Q = 2'b10
  } coin_e;

  localparam int VAL_N = 1;
  localparam int VAL_D = 2;
  localparam int VAL_Q = 5;

  typedef enum logic [2:0] {
    IDLE,
    PROD,
    PICK,
    COIN,
    DONE,
    ERR
  } seq_state_e;

  function automatic logic [2:0] coin_val(input coin_e c);
    logic [2:0] v;
    case (c)
      COIN_Q:  v = 3'(VAL_Q);
      COIN_D:  v = 3'(VAL_D);
      default: v = 3'(VAL_N);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// One coin-denomination inventory counter: loads INIT on reset, saturating
// refill add and single-coin decrement, both usable in the same cycle.
module coin_inventory #(
  parameter int INV_W = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             add_en,
  input  logic [INV_W-1:0] add_cnt,
  input  logic             dec,
  output logic [INV_W-1:0] cnt
);

  logic [INV_W-1:0] cnt_q, cnt_d;
  logic [INV_W:0]   sum;

  // One extra bit catches overflow; dec only happens when cnt_q > 0.
  always_comb begin
    sum   = {1'b0, cnt_q} + (add_en ? {1'b0, add_cnt} : '0) - {{INV_W{1'b0}}, dec};
    cnt_d = sum[INV_W] ? '1 : sum[INV_W-1:0];
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) cnt_q <= INV_W'(INIT);
    else    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vend_change_sequencer.sv
// Releases the product, then pays change coin by coin (greedy) over req/ack.
// Define VEND_ACK_TIMEOUT_EN to abort a stalled handshake after ACK_TO cycles.
module vend_change_sequencer
  import vend_pkg::*;
#(
  parameter int CHANGE_W = 3,
  parameter int INV_W    = 8,
  parameter int N_INIT   = 20,
  parameter int D_INIT   = 20,
  parameter int Q_INIT   = 10,
  parameter int ACK_TO   = 255
) (
  input  logic                clk,
  input  logic                rs,
  input  logic                vend_s,
  input  logic [CHANGE_W-1:0] vend_c,
  output logic                prod_req,
  input  logic                prod_ack,
  output logic                hop_req,
  output logic [1:0]          hop_sel,
  input  logic                hop_ack,
  input  logic                refill,
  input  logic [1:0]          refill_sel,
  input  logic [INV_W-1:0]    refill_cnt,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CHANGE_W-1:0] short_amt,
  output logic [INV_W-1:0]    inv_n,
  output logic [INV_W-1:0]    inv_d,
  output logic [INV_W-1:0]    inv_q,
  output logic                low_change,
  output seq_state_e          dbg_state
);

  // Handshake: a req stays high until the cycle its ack is sampled with it;
  // acks arriving while the matching req is low have no effect.
  seq_state_e          state_q, state_d;
  logic [CHANGE_W-1:0] rem_q, rem_d;
  logic [CHANGE_W-1:0] short_q, short_d;
  coin_e               hop_sel_q, hop_sel_d;
  logic                prod_req_q, prod_req_d;
  logic                hop_req_q, hop_req_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                take;

`ifdef VEND_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TO + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_ack_to;
  assign unused_ack_to = (ACK_TO == 0);
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    short_d   = short_q;
    hop_sel_d = hop_sel_q;
    take      = 1'b0;
    case (state_q)
      IDLE: if (vend_s) begin
        state_d = PROD;
        rem_d   = vend_c;
        short_d = '0;
      end
      PROD: if (prod_ack) state_d = PICK;
      PICK: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (int'(rem_q) >= VAL_Q && inv_q != '0) begin
          hop_sel_d = COIN_Q;
          state_d   = COIN;
        end else if (int'(rem_q) >= VAL_D && inv_d != '0) begin
          hop_sel_d = COIN_D;
          state_d   = COIN;
        end else if (inv_n != '0) begin
          hop_sel_d = COIN_N;
          state_d   = COIN;
        end else begin
          state_d = ERR;
          short_d = rem_q;
        end
      end
      COIN: if (hop_ack) begin
        take    = 1'b1;
        rem_d   = rem_q - CHANGE_W'(coin_val(hop_sel_q));
        state_d = PICK;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef VEND_ACK_TIMEOUT_EN
    // Counts only while a req waits unanswered, so every new req starts at 0.
    to_cnt_d = '0;
    if ((state_q == PROD && !prod_ack) || (state_q == COIN && !hop_ack)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_W'(ACK_TO - 1)) begin
        state_d  = ERR;
        short_d  = rem_q;
        to_cnt_d = '0;
      end
    end
`endif

    prod_req_d = (state_d == PROD);
    hop_req_d  = (state_d == COIN);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      short_q    <= '0;
      hop_sel_q  <= COIN_N;
      prod_req_q <= 1'b0;
      hop_req_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef VEND_ACK_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      short_q    <= short_d;
      hop_sel_q  <= hop_sel_d;
      prod_req_q <= prod_req_d;
      hop_req_q  <= hop_req_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef VEND_ACK_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  coin_inventory #(.INV_W(INV_W), .INIT(N_INIT)) u_inv_n (
    .clk(clk), .rs(rs),
    .add_en(refill && refill_sel == COIN_N), .add_cnt(refill_cnt),
    .dec(take && hop_sel_q == COIN_N), .cnt(inv_n)
  );

  coin_inventory #(.INV_W(INV_W), .INIT(D_INIT)) u_inv_d (
    .clk(clk), .rs(rs),
    .add_en(refill && refill_sel == COIN_D), .add_cnt(refill_cnt),
    .dec(take && hop_sel_q == COIN_D), .cnt(inv_d)
  );

  coin_inventory #(.INV_W(INV_W), .INIT(Q_INIT)) u_inv_q (
    .clk(clk), .rs(rs),
    .add_en(refill && refill_sel == COIN_Q), .add_cnt(refill_cnt),
    .dec(take && hop_sel_q == COIN_Q), .cnt(inv_q)
  );

  assign prod_req   = prod_req_q;
  assign hop_req    = hop_req_q;
  assign hop_sel    = hop_sel_q;
  assign done       = done_q;
  assign err        = err_q;
  assign short_amt  = short_q;
  assign busy       = (state_q != IDLE);
  assign low_change = (inv_n == '0) || (inv_d == '0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Randomized bench for vend_change_sequencer against a greedy change-paying
// reference model kept as plain coin counts.
module tb_vend_change_sequencer;
  import vend_pkg::*;

  localparam int CW = 3;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rs = 1'b1;
  logic          vend_s = 1'b0;
  logic [CW-1:0] vend_c = '0;
  logic          prod_req, hop_req, busy, done, err, low_change;
  logic          prod_ack = 1'b0;
  logic          hop_ack = 1'b0;
  logic [1:0]    hop_sel;
  logic          refill = 1'b0;
  logic [1:0]    refill_sel = 2'b00;
  logic [IW-1:0] refill_cnt = '0;
  logic [CW-1:0] short_amt;
  logic [IW-1:0] inv_n, inv_d, inv_q;
  seq_state_e    dbg_state;

  always #5 clk = ~clk;

  vend_change_sequencer #(
    .CHANGE_W(CW), .INV_W(IW), .N_INIT(20), .D_INIT(20), .Q_INIT(10), .ACK_TO(8)
  ) dut (
    .clk(clk), .rs(rs), .vend_s(vend_s), .vend_c(vend_c),
    .prod_req(prod_req), .prod_ack(prod_ack),
    .hop_req(hop_req), .hop_sel(hop_sel), .hop_ack(hop_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .busy(busy), .done(done), .err(err), .short_amt(short_amt),
    .inv_n(inv_n), .inv_d(inv_d), .inv_q(inv_q),
    .low_change(low_change), .dbg_state(dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  int m_n, m_d, m_q;
  int m_short;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_n = 20; m_d = 20; m_q = 10; m_short = 0;
  endtask

  task automatic check_inv();
    check_eq("inv_n", inv_n, m_n);
    check_eq("inv_d", inv_d, m_d);
    check_eq("inv_q", inv_q, m_q);
    check_eq("low_change", low_change, (m_n == 0 || m_d == 0));
  endtask

  task automatic do_refill(input int sel, input int cnt);
    @(negedge clk);
    refill = 1'b1; refill_sel = 2'(sel); refill_cnt = IW'(cnt);
    @(negedge clk);
    refill = 1'b0;
    case (sel)
      0: m_n = sat(m_n + cnt);
      1: m_d = sat(m_d + cnt);
      2: m_q = sat(m_q + cnt);
      default: ;
    endcase
    check_inv();
  endtask

  // One vend transaction. rf_d refills 3 dimes on the first dime ack;
  // poke pulses vend_s while busy; no_ack never answers the hopper.
  task automatic run_vend(input int c, input int pdly, input int hdly,
                          input bit rf_d, input bit poke, input bit no_ack);
    int rem, exp_cnt, got_cnt, prod_cyc, hop_cyc, hop_tot, quiet;
    logic [15:0] exp_seq, got_seq;
    bit exp_err, rf_used, fin, got_done, got_err, poked;
    logic [CW-1:0] got_short;

    rem = c; exp_cnt = 0; exp_seq = '0; exp_err = 1'b0; rf_used = 1'b0;
    if (no_ack) begin
      exp_err = (c != 0);
    end else begin
      while (rem > 0) begin
        if (rem >= 5 && m_q > 0) begin
          m_q--; rem -= 5; exp_seq = {exp_seq[13:0], 2'b10};
        end else if (rem >= 2 && m_d > 0) begin
          m_d = (rf_d && !rf_used) ? sat(m_d + 3 - 1) : m_d - 1;
          rf_used = 1'b1; rem -= 2; exp_seq = {exp_seq[13:0], 2'b01};
        end else if (m_n > 0) begin
          m_n--; rem -= 1; exp_seq = {exp_seq[13:0], 2'b00};
        end else begin
          exp_err = 1'b1;
          break;
        end
        exp_cnt++;
      end
    end
    m_short = exp_err ? rem : 0;

    @(negedge clk);
    vend_s = 1'b1; vend_c = CW'(c);
    @(negedge clk);
    fin = 1'b0; got_done = 1'b0; got_err = 1'b0; got_short = '0; poked = 1'b0;
    prod_cyc = 0; hop_cyc = 0; hop_tot = 0; got_cnt = 0; got_seq = '0; rf_used = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vend_s = 1'b0; prod_ack = 1'b0; hop_ack = 1'b0; refill = 1'b0;
      if (done || err) begin
        fin = 1'b1; got_done = done; got_err = err; got_short = short_amt;
      end else if (prod_req) begin
        prod_cyc++;
        if (poke && !poked) begin
          vend_s = 1'b1; vend_c = CW'($urandom_range(1, 7)); poked = 1'b1;
        end
        if (prod_cyc == pdly) prod_ack = 1'b1;
      end else if (hop_req) begin
        hop_cyc++; hop_tot++;
        if (!no_ack && hop_cyc == hdly) begin
          hop_ack = 1'b1; got_seq = {got_seq[13:0], hop_sel}; got_cnt++; hop_cyc = 0;
          if (rf_d && !rf_used && hop_sel == 2'b01) begin
            refill = 1'b1; refill_sel = 2'b01; refill_cnt = IW'(3); rf_used = 1'b1;
          end
        end
      end
    end
    check_eq("finished", fin, 1);
    check_eq("prod_cycles", prod_cyc, pdly);
    check_eq("coin_cnt", got_cnt, exp_cnt);
    check_eq("coin_seq", got_seq, exp_seq);
    check_eq("done", got_done, !exp_err);
    check_eq("err", got_err, exp_err);
    check_eq("short_amt", got_short, m_short);
`ifdef VEND_ACK_TIMEOUT_EN
    if (no_ack) check_eq("to_cycles", hop_tot, 8);
`endif
    @(negedge clk);
    check_eq("pulse_width", done | err, 0);
    check_eq("busy_idle", busy, 0);
    check_eq("short_held", short_amt, m_short);
    check_inv();
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (prod_req) quiet++;
    end
    check_eq("no_extra_prod", quiet, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_hop_req", hop_req, 0);
    rs = 1'b0;
    @(negedge clk);
    check_eq("rst_state", dbg_state, 32'(IDLE));
    check_eq("rst_busy", busy, 0);
    check_eq("rst_prod_req", prod_req, 0);
    check_eq("rst_pulses", done | err, 0);
    check_eq("rst_short", short_amt, 0);
    check_inv();

    run_vend(0, 3, 1, 0, 0, 0);
    run_vend(4, 1, 1, 0, 1, 0);
    run_vend(4, 2, 1, 1, 0, 0);
    while (m_q > 1) run_vend(7, 1, 1, 0, 0, 0);
    run_vend(7, 2, 2, 0, 0, 0);
    while (m_n > 0) run_vend(1, 1, 1, 0, 0, 0);
    run_vend(3, 1, 1, 0, 0, 0);

    do_refill(0, 250);
    do_refill(0, 10);
    do_refill(3, 40);
    do_refill(1, 7);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 40));
      run_vend($urandom_range(0, 7), $urandom_range(1, 4), $urandom_range(1, 3),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset in the middle of a coin handshake.
    @(negedge clk);
    vend_s = 1'b1; vend_c = CW'(5);
    @(negedge clk);
    vend_s = 1'b0; prod_ack = 1'b1;
    @(negedge clk);
    prod_ack = 1'b0;
    for (int i = 0; i < 10 && !hop_req; i++) @(negedge clk);
    check_eq("mid_coin_req", hop_req, 1);
    #2 rs = 1'b1;
    #1;
    model_reset();
    check_eq("rst_drop_req", hop_req, 0);
    check_eq("rst_drop_busy", busy, 0);
    check_inv();
    @(negedge clk);
    rs = 1'b0;

`ifdef VEND_ACK_TIMEOUT_EN
    run_vend(5, 1, 1, 0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
